// File: rtl/sap_core_p.sv
// sap_core_p: parametrised SAP-style accumulator CPU with internal RAM, variable-length
// microcode and a host load port. Define SAP_CORE_TRACE_EN for a per-cycle $display trace.
module sap_core_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              run,
  output logic              busy,
  output logic              halted,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pc_dbg
);

  generate
    if (DATA_W < ADDR_W + 4) begin : g_width_check
      $fatal(1, "sap_core_p: DATA_W must be >= ADDR_W+4");
    end
  endgenerate

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [1:0]        state;
  logic [2:0]        step;
  logic [2:0]        last_step;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W+3:0] ir;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] breg;
  logic              cf;
  logic              zf;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic [DATA_W-1:0] mem_rd;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] operand_ext;
  logic              is_sub;
  logic [DATA_W:0]   alu_sum;

  assign mem_rd      = mem[mar];
  assign opcode      = ir[ADDR_W+3:ADDR_W];
  assign operand     = ir[ADDR_W-1:0];
  assign operand_ext = {{(DATA_W-ADDR_W){1'b0}}, operand};
  assign is_sub      = (opcode == OP_SUB);
  // SUB is A + ~B + 1, so the carry out reads as "no borrow"
  assign alu_sum     = {1'b0, acc} + {1'b0, (is_sub ? ~breg : breg)} + {{DATA_W{1'b0}}, is_sub};

  assign busy   = (state == S_RUN);
  assign halted = (state == S_HALT);
  assign pc_dbg = pc;

  always_comb begin
    last_step = T2;
    case (opcode)
      OP_LDA, OP_STA: last_step = T3;
      OP_ADD, OP_SUB: last_step = T4;
      default:        last_step = T2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      step      <= T0;
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      acc       <= '0;
      breg      <= '0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (run) begin
            state <= S_RUN;
            step  <= T0;
            pc    <= '0;
            acc   <= '0;
            breg  <= '0;
            cf    <= 1'b0;
            zf    <= 1'b0;
          end
        end
        S_RUN: begin
          // T0/T1 never match last_step, which is T2 at the earliest
          step <= (step == last_step) ? T0 : step + 3'd1;
          case (step)
            T0: mar <= pc;
            T1: begin
              ir <= mem_rd[ADDR_W+3:0];
              pc <= pc + 1'b1;
            end
            T2: begin
              case (opcode)
                OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
                OP_LDI: acc <= operand_ext;
                OP_JMP: pc <= operand;
                OP_JC:  if (cf) pc <= operand;
                OP_JZ:  if (zf) pc <= operand;
                OP_OUT: begin
                  out_data  <= acc;
                  out_valid <= 1'b1;
                end
                OP_HLT: state <= S_HALT;
                default: ;
              endcase
            end
            T3: begin
              if (opcode == OP_LDA) acc <= mem_rd;
              if (is_sub || opcode == OP_ADD) breg <= mem_rd;
            end
            T4: begin
              acc <= alu_sum[DATA_W-1:0];
              cf  <= alu_sum[DATA_W];
              zf  <= (alu_sum[DATA_W-1:0] == '0);
            end
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Host loads and STA never coincide: one needs RUN, the other needs not-RUN
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (load_we && state != S_RUN)
        mem[load_addr] <= load_data;
      else if (state == S_RUN && step == T3 && opcode == OP_STA)
        mem[mar] <= acc;
    end
  end

`ifdef SAP_CORE_TRACE_EN
  always @(posedge clk) begin
    if (!clr && state == S_RUN) begin
      case (step)
        T0: $display("mar r %h", pc);
        T1: begin
          $display("instReg r %h", mem_rd[ADDR_W+3:0]);
          $display("pc r %b", pc + 1'b1);
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: $display("mar r %h", operand);
            OP_LDI: $display("aReg r %h", operand_ext);
            OP_JMP: if (operand != pc) $display("pc r %b", operand);
            OP_JC:  if (cf && operand != pc) $display("pc r %b", operand);
            OP_JZ:  if (zf && operand != pc) $display("pc r %b", operand);
            OP_OUT: $display("outReg r %h", acc);
            default: ;
          endcase
        end
        T3: begin
          if (opcode == OP_LDA) $display("aReg r %h", mem_rd);
          if (is_sub || opcode == OP_ADD) $display("bReg r %h", mem_rd);
          if (opcode == OP_STA) $display("ram r [%h] %h", mar, acc);
        end
        T4: begin
          $display("alu res:%h sub:%b cf:%b zf:%b", alu_sum[DATA_W-1:0], is_sub,
                   alu_sum[DATA_W], (alu_sum[DATA_W-1:0] == '0));
          $display("aReg r %h", alu_sum[DATA_W-1:0]);
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) $display("#");
`else
`endif

endmodule

// File: tb/tb_sap_core_p.sv
// Directed testbench for sap_core_p: loads small programs, runs them and checks timing,
// outputs, flags and host/reset interactions against hand-computed values.
module tb_sap_core_p;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic          run = 1'b0;
  logic          busy;
  logic          halted;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [AW-1:0] pc_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  int first_pulse = -1;
  logic [DW-1:0] prog [16];

  sap_core_p #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .clr(clr), .load_we(load_we), .load_addr(load_addr),
    .load_data(load_data), .run(run), .busy(busy), .halted(halted),
    .out_data(out_data), .out_valid(out_valid), .pc_dbg(pc_dbg)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later and log out_valid pulses
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = cyc;
    end
  endtask

  task automatic runTo(input int n);
    while (cyc < n) tick();
  endtask

  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    load_we = 1'b1; load_addr = addr; load_data = data;
    tick();
    load_we = 1'b0;
  endtask

  task automatic doReset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic clearProg();
    for (int i = 0; i < 16; i++) prog[i] = '0;
  endtask

  task automatic loadAll();
    for (int i = 0; i < 16; i++) applyStimulus(AW'(i), prog[i]);
  endtask

  // The run edge itself is cycle 0; the first T0 is cycle 1
  task automatic startRun();
    run = 1'b1;
    tick();
    run = 1'b0;
    cyc = 0; pulses = 0; first_pulse = -1;
  endtask

  task automatic loadProgram1();
    clearProg();
    prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h90; prog[3] = 8'hF0;
    prog[14] = 8'h1C; prog[15] = 8'h0E;
    loadAll();
  endtask

  initial begin
    // Reset state
    doReset();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_pc", pc_dbg, 0);
    checkOutput("rst_out", out_data, 0);
    checkOutput("rst_valid", out_valid, 0);

    // Program 1: 1C + 0E = 2A, OUT, HLT
    loadProgram1();
    startRun();
    checkOutput("p1_busy", busy, 1);
    runTo(11);
    checkOutput("p1_valid_pre", out_valid, 0);
    runTo(12);
    checkOutput("p1_valid", out_valid, 1);
    checkOutput("p1_out", out_data, 8'h2A);
    runTo(14);
    checkOutput("p1_halt_pre", halted, 0);
    runTo(15);
    checkOutput("p1_halted", halted, 1);
    checkOutput("p1_busy_end", busy, 0);
    checkOutput("p1_pulses", pulses, 1);
    checkOutput("p1_pulse_cyc", first_pulse, 12);
    checkOutput("p1_cf", dut.cf, 0);
    checkOutput("p1_zf", dut.zf, 0);

    // Program 2: LDI 5, SUB 5 -> zero, JZ taken over OUT
    doReset();
    clearProg();
    prog[0] = 8'h55; prog[1] = 8'h3F; prog[2] = 8'h84; prog[3] = 8'h90; prog[4] = 8'hF0;
    prog[15] = 8'h05;
    loadAll();
    startRun();
    runTo(13);
    checkOutput("p2_halt_pre", halted, 0);
    runTo(14);
    checkOutput("p2_halted", halted, 1);
    checkOutput("p2_acc", dut.acc, 0);
    checkOutput("p2_zf", dut.zf, 1);
    checkOutput("p2_cf", dut.cf, 1);
    checkOutput("p2_pulses", pulses, 0);
    checkOutput("p2_pc", pc_dbg, 5);

    // Program 3: FF + 01 overflows, JC then HLT
    doReset();
    clearProg();
    prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h73; prog[3] = 8'hF0;
    prog[14] = 8'hFF; prog[15] = 8'h01;
    loadAll();
    startRun();
    runTo(14);
    checkOutput("p3_halt_pre", halted, 0);
    runTo(15);
    checkOutput("p3_halted", halted, 1);
    checkOutput("p3_acc", dut.acc, 0);
    checkOutput("p3_cf", dut.cf, 1);
    checkOutput("p3_zf", dut.zf, 1);
    checkOutput("p3_pc", pc_dbg, 4);

    // All NOPs: PC walks the whole RAM and wraps
    doReset();
    clearProg();
    loadAll();
    startRun();
    runTo(2);
    checkOutput("nop_pc1", pc_dbg, 1);
    runTo(45);
    checkOutput("nop_pc15", pc_dbg, 15);
    runTo(48);
    checkOutput("nop_wrap", pc_dbg, 0);
    checkOutput("nop_busy", busy, 1);
    runTo(50);
    checkOutput("nop_pc_again", pc_dbg, 1);

    // Load ignored while running, clr at ADD T3 aborts, rerun still works
    doReset();
    loadProgram1();
    startRun();
    runTo(2);
    applyStimulus(4'd0, 8'hF0);
    runTo(7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_halted", halted, 0);
    checkOutput("clr_acc", dut.acc, 0);
    checkOutput("clr_pc", pc_dbg, 0);
    checkOutput("clr_mem0", dut.mem[0], 8'h1E);
    startRun();
    runTo(12);
    checkOutput("rerun_valid", out_valid, 1);
    checkOutput("rerun_out", out_data, 8'h2A);
    runTo(15);
    checkOutput("rerun_halted", halted, 1);

    // Unused opcodes as NOPs, loaded from HALT; word 0 written in the run cycle
    clearProg();
    prog[1] = 8'hB0; prog[2] = 8'hC0; prog[3] = 8'hD0; prog[4] = 8'hE0; prog[5] = 8'hF0;
    for (int i = 1; i < 16; i++) applyStimulus(AW'(i), prog[i]);
    load_we = 1'b1; load_addr = 4'd0; load_data = 8'hA0;
    startRun();
    load_we = 1'b0;
    checkOutput("ill_busy", busy, 1);
    runTo(17);
    checkOutput("ill_halt_pre", halted, 0);
    runTo(18);
    checkOutput("ill_halted", halted, 1);
    checkOutput("ill_acc", dut.acc, 0);
    checkOutput("ill_pc", pc_dbg, 6);

    // STA rewrites the next instruction (OUT -> HLT) before it is fetched
    doReset();
    clearProg();
    prog[0] = 8'h1E; prog[1] = 8'h42; prog[2] = 8'h90; prog[14] = 8'hF0;
    loadAll();
    startRun();
    runTo(10);
    checkOutput("sta_halt_pre", halted, 0);
    runTo(11);
    checkOutput("sta_halted", halted, 1);
    checkOutput("sta_mem2", dut.mem[2], 8'hF0);
    checkOutput("sta_pulses", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
